// File: rtl/adjust_pulse_gen_pkg.sv
// Shared FSM state, direction codes and button-pair decode for the adjust pulse generator.
package adjust_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic valid;
    logic dir;
  } dec_t;

  // Pair is {up, down}; both pressed is treated the same as none pressed.
  function automatic dec_t decode_btn(input logic [1:0] s);
    dec_t d;
    d.valid = 1'b0;
    d.dir   = DIR_UP;
    case (s)
      2'b10: begin d.valid = 1'b1; d.dir = DIR_UP;   end
      2'b01: begin d.valid = 1'b1; d.dir = DIR_DOWN; end
      default: begin d.valid = 1'b0; d.dir = DIR_UP; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/adjust_pulse_gen_sync_debounce.sv
// Two-flop synchroniser plus stability counter for a W-bit group of raw buttons.
module sync_debounce #(
  parameter int W          = 2,
  parameter int DEB_CYCLES = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [W-1:0]  r_meta;
  logic [W-1:0]  r_sync;
  logic [W-1:0]  r_last;
  logic [W-1:0]  r_stable;
  logic [CW-1:0] r_cnt;

  // The whole group restarts its count on any bit change, so a mixed
  // transition can never be accepted half-way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_last   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_last <= r_sync;
      if (r_sync != r_last) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_stable <= r_last;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/adjust_pulse_gen.sv
// Button-to-counter adjust pulser: one pulse per press, then auto-repeat while held.
//  state     | meaning
//  ST_IDLE   | no direction accepted, waiting for a debounced UP or DOWN
//  ST_DELAY  | first pulse sent, counting the hold delay to the first repeat
//  ST_REPEAT | auto-repeating at the repeat interval while the button is held
module adjust_pulse_gen
  import adjust_pulse_gen_pkg::*;
#(
  parameter int DEB_CYCLES    = 20,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic en,
  output logic Up_down,
  output logic active
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [1:0] w_stable;
  dec_t       w_dec;
  logic       w_same;

  state_t      r_state;
  logic        r_dir;
  logic [TW-1:0] r_timer;
  logic        r_en;
  logic        r_ud;
  logic        r_act;

  sync_debounce #(
    .W          (2),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sync_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_raw    ({btn_up, btn_down}),
    .o_stable (w_stable)
  );

  assign w_dec  = decode_btn(w_stable);
  assign w_same = w_dec.valid && (w_dec.dir == r_dir);

  // A direction change always passes through IDLE, so en can never carry
  // two directions back to back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_UP;
      r_timer <= '0;
      r_en    <= 1'b0;
      r_ud    <= DIR_UP;
      r_act   <= 1'b0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dec.valid) begin
            r_en    <= 1'b1;
            r_ud    <= w_dec.dir;
            r_dir   <= w_dec.dir;
            r_timer <= '0;
            r_state <= ST_DELAY;
            r_act   <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (!w_same) begin
            r_state <= ST_IDLE;
            r_act   <= 1'b0;
          end else if (r_timer == TW'(HOLD_CYCLES - 1)) begin
            r_en    <= 1'b1;
            r_timer <= '0;
            r_state <= ST_REPEAT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_REPEAT: begin
          if (!w_same) begin
            r_state <= ST_IDLE;
            r_act   <= 1'b0;
          end else if (r_timer == TW'(REPEAT_CYCLES - 1)) begin
            r_en    <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_act   <= 1'b0;
        end
      endcase
    end
  end

  assign en      = r_en;
  assign Up_down = r_ud;
  assign active  = r_act;

endmodule
